// File: rtl/shift_sipo.sv
// Serial-in, parallel-out shift register with a word-boundary counter.
// One bit is sampled per rising edge; word_valid strobes for one cycle each
// time WIDTH new bits have been collected since reset.
module shift_sipo #(
  parameter int unsigned WIDTH  = 4,
  parameter bit          LSB_IN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_in,
  output logic [WIDTH-1:0]         q_out,
  output logic                     word_valid,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  // Reject unsupported widths at elaboration time.
  if (WIDTH < 2 || WIDTH > 32) begin : gen_bad_width
    $error("shift_sipo: WIDTH must be in 2..32");
  end

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             cnt_last;

  // Next shift-register contents; the entry end is chosen by LSB_IN.
  always_comb begin
    shift_d = shift_q;
    if (LSB_IN) begin
      shift_d = {shift_q[WIDTH-2:0], s_in};
    end else begin
      shift_d = {s_in, shift_q[WIDTH-1:1]};
    end
  end

  // Bit counter wraps after WIDTH bits; the wrap edge raises word_valid.
  always_comb begin
    cnt_last = (cnt_q == CntMax);
    cnt_d    = cnt_last ? '0 : cnt_q + CntOne;
    valid_d  = cnt_last;
  end

  // State registers; reset clears the partial word and restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // All outputs come straight from flops.
  assign q_out      = shift_q;
  assign bit_cnt    = cnt_q;
  assign word_valid = valid_q;

endmodule

// File: tb/tb_shift_sipo.sv
// Directed bench for shift_sipo: one instance per shift direction, WIDTH=4.
module tb_shift_sipo;

  logic       clk;
  logic       rst;
  logic       s_in;
  logic [3:0] q_lsb, q_msb;
  logic       v_lsb, v_msb;
  logic [1:0] c_lsb, c_msb;

  int tests;
  int fails;

  shift_sipo #(.WIDTH(4), .LSB_IN(1'b1)) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .s_in       (s_in),
    .q_out      (q_lsb),
    .word_valid (v_lsb),
    .bit_cnt    (c_lsb)
  );

  shift_sipo #(.WIDTH(4), .LSB_IN(1'b0)) dut_msb (
    .clk        (clk),
    .rst        (rst),
    .s_in       (s_in),
    .q_out      (q_msb),
    .word_valid (v_msb),
    .bit_cnt    (c_msb)
  );

  // 20 ns period, rising edges at 10, 30, 50, ...
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Drive one bit, take one rising edge, settle mid-cycle.
  task automatic shift(input logic b);
    s_in = b;
    @(posedge clk);
    #5;
  endtask

  // Assert reset mid-cycle, hold across one edge, release mid-cycle.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #5;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) shift(1'b1);
    // Asynchronous assertion between edges with s_in high.
    s_in = 1'b1;
    rst  = 1'b1;
    #1;
    tests++;
    if ({q_lsb, c_lsb, v_lsb} !== {4'b0000, 2'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_async_lsb: q=%b cnt=%0d valid=%b, expected q=0000 cnt=0 valid=0",
               q_lsb, c_lsb, v_lsb);
    end
    tests++;
    if ({q_msb, c_msb, v_msb} !== {4'b0000, 2'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_async_msb: q=%b cnt=%0d valid=%b, expected q=0000 cnt=0 valid=0",
               q_msb, c_msb, v_msb);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #5;
      tests++;
      if ({q_lsb, c_lsb, v_lsb} !== {4'b0000, 2'd0, 1'b0}) begin
        fails++;
        $display("FAIL reset_hold[%0d]: q=%b cnt=%0d valid=%b, expected q=0000 cnt=0 valid=0",
                 i, q_lsb, c_lsb, v_lsb);
      end
    end
    rst = 1'b0;
  endtask

  // Continues straight into test_drain without a reset in between.
  task automatic test_fill();
    logic [3:0] eq [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111};
    logic [1:0] ec [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    logic       ev [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      shift(1'b1);
      tests++;
      if ({q_lsb, c_lsb, v_lsb} !== {eq[i], ec[i], ev[i]}) begin
        fails++;
        $display("FAIL fill[%0d]: q=%b cnt=%0d valid=%b, expected q=%b cnt=%0d valid=%b",
                 i, q_lsb, c_lsb, v_lsb, eq[i], ec[i], ev[i]);
      end
    end
  endtask

  task automatic test_drain();
    logic [3:0] eq [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [1:0] ec [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    logic       ev [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      shift(1'b0);
      tests++;
      if ({q_lsb, c_lsb, v_lsb} !== {eq[i], ec[i], ev[i]}) begin
        fails++;
        $display("FAIL drain[%0d]: q=%b cnt=%0d valid=%b, expected q=%b cnt=%0d valid=%b",
                 i, q_lsb, c_lsb, v_lsb, eq[i], ec[i], ev[i]);
      end
    end
  endtask

  task automatic test_pattern();
    logic       bits [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] eq [8] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011,
                           4'b0110, 4'b1100, 4'b1001, 4'b0010};
    logic [1:0] ec [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic       ev [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      shift(bits[i]);
      tests++;
      if ({q_lsb, c_lsb, v_lsb} !== {eq[i], ec[i], ev[i]}) begin
        fails++;
        $display("FAIL pattern[%0d]: q=%b cnt=%0d valid=%b, expected q=%b cnt=%0d valid=%b",
                 i, q_lsb, c_lsb, v_lsb, eq[i], ec[i], ev[i]);
      end
    end
  endtask

  task automatic test_midword_reset();
    logic       ev [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0] ec [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    shift(1'b1);
    shift(1'b1);
    tests++;
    if ({q_lsb, c_lsb} !== {4'b0011, 2'd2}) begin
      fails++;
      $display("FAIL midword_pre: q=%b cnt=%0d, expected q=0011 cnt=2", q_lsb, c_lsb);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({q_lsb, c_lsb, v_lsb} !== {4'b0000, 2'd0, 1'b0}) begin
      fails++;
      $display("FAIL midword_async: q=%b cnt=%0d valid=%b, expected q=0000 cnt=0 valid=0",
               q_lsb, c_lsb, v_lsb);
    end
    @(posedge clk);
    #5;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      shift(1'b0);
      tests++;
      if ({q_lsb, c_lsb, v_lsb} !== {4'b0000, ec[i], ev[i]}) begin
        fails++;
        $display("FAIL midword_after[%0d]: q=%b cnt=%0d valid=%b, expected q=0000 cnt=%0d valid=%b",
                 i, q_lsb, c_lsb, v_lsb, ec[i], ev[i]);
      end
    end
  endtask

  task automatic test_direction();
    logic       bits [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] em [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [3:0] el [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic       ev [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      shift(bits[i]);
      tests++;
      if ({q_msb, v_msb} !== {em[i], ev[i]}) begin
        fails++;
        $display("FAIL direction_msb[%0d]: q=%b valid=%b, expected q=%b valid=%b",
                 i, q_msb, v_msb, em[i], ev[i]);
      end
      tests++;
      if (q_lsb !== el[i]) begin
        fails++;
        $display("FAIL direction_lsb[%0d]: q=%b, expected q=%b", i, q_lsb, el[i]);
      end
    end
  endtask

  // Strobe must recur every 4th edge over several consecutive words.
  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      shift(i[0]);
      tests++;
      if (v_lsb !== ((i % 4) == 0)) begin
        fails++;
        $display("FAIL back_to_back[%0d]: valid=%b, expected valid=%b",
                 i, v_lsb, ((i % 4) == 0));
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    s_in  = 1'b0;
    #5;
    test_reset();
    test_fill();
    test_drain();
    test_pattern();
    test_midword_reset();
    test_direction();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
